// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared encodings and default latencies for the multiply/divide unit
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module   : mdu_arith
// Purpose  : Combinational MIPS mult/multu/div/divu datapath; result = {hi,lo}
// Revision : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  md_op,
    output logic [63:0] result,
    output logic        div0
);

    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign w_a_ext  = w_signed ? {{32{src_a[31]}}, src_a} : {32'h0, src_a};
    assign w_b_ext  = w_signed ? {{32{src_b[31]}}, src_b} : {32'h0, src_b};

    // Signed division runs on magnitudes, so INT_MIN / -1 wraps to INT_MIN without overflow.
    assign w_mag_a  = (w_signed && src_a[31]) ? (32'h0 - src_a) : src_a;
    assign w_mag_b  = (w_signed && src_b[31]) ? (32'h0 - src_b) : src_b;
    assign w_div_b  = (src_b == 32'h0) ? 32'h1 : w_mag_b;
    assign w_quo    = w_mag_a / w_div_b;
    assign w_rem    = w_mag_a % w_div_b;

    always_comb begin
        result = 64'h0;
        div0   = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: begin
                result = w_a_ext * w_b_ext;
            end
            default: begin
                div0 = (src_b == 32'h0);
                result[31:0]  = (w_signed && (src_a[31] ^ src_b[31])) ? (32'h0 - w_quo) : w_quo;
                result[63:32] = (w_signed && src_a[31]) ? (32'h0 - w_rem) : w_rem;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : MIPS multiply/divide sequencer owning HI/LO, with ID stall request.
//            Optional MDU_CANCEL_EN adds a cancel (flush) input.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use_ID,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
`ifdef MDU_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [31:0]   r_hi, w_hi_nxt;
    logic [31:0]   r_lo, w_lo_nxt;
    logic [63:0]   r_pend, w_pend_nxt;
    logic          r_pend_ok, w_pend_ok_nxt;
    logic [63:0]   w_result;
    logic          w_div0;
    logic          w_cancel;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    mdu_arith u_arith (
        .src_a  (src_a),
        .src_b  (src_b),
        .md_op  (md_op),
        .result (w_result),
        .div0   (w_div0)
    );

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == S_BUSY);
    assign md_stall = md_use_ID & (md_start | busy);

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_nxt    = r_pend;
        w_pend_ok_nxt = r_pend_ok;
        case (r_state)
            S_IDLE: begin
                if (!w_cancel) begin
                    if (md_start) begin
                        w_state_nxt   = S_BUSY;
                        w_count_nxt   = (md_op == MD_DIV || md_op == MD_DIVU) ? DIV_LAST : MULT_LAST;
                        w_pend_nxt    = w_result;
                        w_pend_ok_nxt = ~w_div0;
                    end else begin
                        if (hi_we) w_hi_nxt = wdata;
                        if (lo_we) w_lo_nxt = wdata;
                    end
                end
            end
            S_BUSY: begin
                if (w_cancel) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - CW'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    // Divide-by-zero leaves HI/LO untouched after the full busy period.
                    if (r_pend_ok) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_pend    <= 64'h0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_ok <= w_pend_ok_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl against a behavioural HI/LO model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] src_a, src_b, wdata;
    logic        hi_we, lo_we, md_use_ID;
    logic        cancel;
    logic [31:0] hi, lo;
    logic        busy, md_stall;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .md_use_ID (md_use_ID),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .md_stall  (md_stall)
`ifdef MDU_CANCEL_EN
        ,
        .cancel    (cancel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic in 64-bit integers: no overflow corner exists at this width.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [63:0] res, output bit ok);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint          q, r;
        ok  = 1;
        res = 64'h0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: if (b == 0) ok = 0; else begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: if (b == 0) ok = 0; else begin
                res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    bit          m_ok;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_ok = 0;
        end else if (m_left > 0) begin
            if (cancel) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0 && m_ok) {m_hi, m_lo} = m_pend;
            end
        end else if (!cancel) begin
            if (md_start) begin
                ref_op(md_op, src_a, src_b, m_pend, m_ok);
                m_left = md_op[1] ? DIV_N : MULT_N;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (reset && chk_en) begin
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("busy", {31'h0, busy}, {31'h0, m_left > 0});
            check("md_stall", {31'h0, md_stall}, {31'h0, md_use_ID & (md_start | (m_left > 0))});
        end
    end

    task automatic idle_in();
        md_start = 0; md_op = 0; src_a = 0; src_b = 0;
        hi_we = 0; lo_we = 0; wdata = 0; md_use_ID = 0; cancel = 0;
    endtask

    task automatic write_hl(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        idle_in(); hi_we = h; lo_we = l; wdata = d;
        @(negedge clk);
        idle_in();
    endtask

    // Starts one op and counts busy cycles observed until busy drops.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit use_id, output int n);
        @(negedge clk);
        idle_in(); md_start = 1; md_op = op; src_a = a; src_b = b; md_use_ID = use_id;
        @(negedge clk);
        md_start = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check("busy_timeout", 32'(n), 32'd0);
        md_use_ID = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        idle_in();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        chk_en = 1;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        write_hl(1, 0, 32'h1234);
        check("mthi", hi, 32'h1234);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, n);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, n);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, n);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        write_hl(1, 0, 32'hA);
        write_hl(0, 1, 32'hB);
        run_op(2'b11, 32'd5, 32'd0, 0, n);
        check("div0_cycles", 32'(n), 32'd10);
        check("div0_hi", hi, 32'hA);
        check("div0_lo", lo, 32'hB);

        // Stall during busy and ignored restart mid-operation.
        @(negedge clk);
        idle_in(); md_start = 1; md_op = 2'b00; src_a = 32'd6; src_b = 32'd7; md_use_ID = 1;
        @(negedge clk);
        md_start = 0;
        check("stall_busy", {31'h0, md_stall}, 32'h1);
        @(negedge clk);
        md_start = 1; md_op = 2'b01; src_a = 32'd100; src_b = 32'd100; hi_we = 1; wdata = 32'h5555;
        @(negedge clk);
        md_start = 0; hi_we = 0;
        repeat (3) @(negedge clk);
        check("stall_after", {31'h0, md_stall}, 32'h0);
        check("restart_lo", lo, 32'd42);
        check("restart_hi", hi, 32'd0);
        md_use_ID = 0;

        // Start together with mthi: the write is dropped.
        @(negedge clk);
        md_start = 1; md_op = 2'b01; src_a = 32'd3; src_b = 32'd3; hi_we = 1; lo_we = 1; wdata = 32'h7777;
        @(negedge clk);
        idle_in();
        repeat (5) @(negedge clk);
        check("start_wins_lo", lo, 32'd9);
        check("start_wins_hi", hi, 32'd0);

`ifdef MDU_CANCEL_EN
        @(negedge clk);
        idle_in(); md_start = 1; md_op = 2'b10; src_a = 32'd50; src_b = 32'd7;
        @(negedge clk);
        md_start = 0;
        repeat (2) @(negedge clk);
        cancel = 1;
        @(negedge clk);
        cancel = 0;
        check("cancel_busy", {31'h0, busy}, 32'h0);
        check("cancel_lo", lo, 32'd9);
`endif

        // Reset in the middle of a divide.
        @(negedge clk);
        idle_in(); md_start = 1; md_op = 2'b10; src_a = 32'd77; src_b = 32'd5;
        @(negedge clk);
        md_start = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            idle_in();
            md_start  = ($urandom_range(0, 3) == 0);
            md_op     = 2'($urandom_range(0, 3));
            src_a     = pick();
            src_b     = pick();
            hi_we     = ($urandom_range(0, 5) == 0);
            lo_we     = ($urandom_range(0, 5) == 0);
            wdata     = $urandom;
            md_use_ID = $urandom_range(0, 1) == 1;
`ifdef MDU_CANCEL_EN
            cancel    = ($urandom_range(0, 15) == 0);
`endif
        end
        @(negedge clk);
        idle_in();
        repeat (DIV_N + 2) @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
